ct_vfdsu_tag_pipe: RTL and testbench



---
 rtl/ct_vfdsu_pkg.sv | 39 +++
 rtl/ct_vfdsu_tag_pipe_if.sv | 45 ++++
 rtl/ct_vfdsu_iter_cnt.sv | 35 +++
 rtl/ct_vfdsu_tag_pipe.sv | 132 +++++++++++++
 tb/tb_ct_vfdsu_tag_pipe.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_vfdsu_pkg.sv
// Shared encodings and the per-stage tag record for the VFDSU tag pipeline.
package ct_vfdsu_pkg;

    // Ceiling widths of the stored tag fields; narrower configurations zero-extend into them.
    localparam int unsigned TAG_IID_W  = 16;
    localparam int unsigned TAG_EREG_W = 8;
    localparam int unsigned TAG_VREG_W = 8;

    typedef enum logic [1:0] {
        FmtHalf   = 2'b00,
        FmtSingle = 2'b01,
        FmtDouble = 2'b10,
        FmtRsvd   = 2'b11
    } ct_vfdsu_fmt_e;

    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpDiv  = 2'b01,
        OpSqrt = 2'b10,
        OpRsvd = 2'b11
    } ct_vfdsu_op_e;

    typedef struct packed {
        ct_vfdsu_op_e            op;
        ct_vfdsu_fmt_e           fmt;
        logic [2:0]              rm;
        logic [TAG_IID_W-1:0]    iid;
        logic [TAG_EREG_W-1:0]   dst_ereg;
        logic [TAG_VREG_W-1:0]   dst_vreg;
    } ct_vfdsu_tag_t;

    function automatic int unsigned ct_vfdsu_max3(input int unsigned a, input int unsigned b,
                                                  input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ct_vfdsu_tag_pipe_if.sv
// Issue, flush, writeback and stage-status signals of the VFDSU tag pipeline.
interface ct_vfdsu_tag_pipe_if #(
    parameter int unsigned IID_W  = 7,
    parameter int unsigned EREG_W = 5,
    parameter int unsigned VREG_W = 7
);
    logic              issue_vld;
    logic              issue_rdy;
    logic [1:0]        issue_op;
    logic [1:0]        issue_fmt;
    logic [IID_W-1:0]  issue_iid;
    logic [EREG_W-1:0] issue_dst_ereg;
    logic [VREG_W-1:0] issue_dst_vreg;
    logic [2:0]        issue_rm;
    logic              flush;
    logic              s1_vld;
    logic              s2_vld;
    logic [1:0]        s1_op;
    logic [1:0]        s1_fmt;
    logic [2:0]        s1_rm;
    logic              iter_start;
    logic              iter_last;
    logic              wb_vld;
    logic              wb_ack;
    logic [IID_W-1:0]  wb_iid;
    logic [EREG_W-1:0] wb_dst_ereg;
    logic [VREG_W-1:0] wb_dst_vreg;
    logic [1:0]        wb_op;
    logic [1:0]        wb_fmt;
    logic              busy;

    modport master (
        output issue_vld, issue_op, issue_fmt, issue_iid, issue_dst_ereg, issue_dst_vreg,
               issue_rm, flush, wb_ack,
        input  issue_rdy, s1_vld, s2_vld, s1_op, s1_fmt, s1_rm, iter_start, iter_last,
               wb_vld, wb_iid, wb_dst_ereg, wb_dst_vreg, wb_op, wb_fmt, busy
    );

    modport slave (
        input  issue_vld, issue_op, issue_fmt, issue_iid, issue_dst_ereg, issue_dst_vreg,
               issue_rm, flush, wb_ack,
        output issue_rdy, s1_vld, s2_vld, s1_op, s1_fmt, s1_rm, iter_start, iter_last,
               wb_vld, wb_iid, wb_dst_ereg, wb_dst_vreg, wb_op, wb_fmt, busy
    );
endinterface

// File: rtl/ct_vfdsu_iter_cnt.sv
// S2 iteration counter: load on entry, count down to zero, hold at zero.
module ct_vfdsu_iter_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/ct_vfdsu_tag_pipe.sv
// Stallable, flushable tag pipeline S1..S_DEPTH for the VFDSU with an iterating S2.
// Optional macro CT_VFDSU_HALF_EN: half format uses ITER_H instead of ITER_D.
module ct_vfdsu_tag_pipe
    import ct_vfdsu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned IID_W  = 7,
    parameter int unsigned VREG_W = 7,
    parameter int unsigned EREG_W = 5,
    parameter int unsigned ITER_D = 15,
    parameter int unsigned ITER_S = 8,
    parameter int unsigned ITER_H = 4
) (
    input logic                forever_cpuclk,
    input logic                cpurst,
    ct_vfdsu_tag_pipe_if.slave pif
);
    localparam int unsigned ITER_MAX = ct_vfdsu_max3(ITER_D, ITER_S, ITER_H);
    localparam int unsigned CNT_W    = ($clog2(ITER_MAX) < 1) ? 1 : $clog2(ITER_MAX);

    logic [DEPTH-1:0] vld_q, vld_d, adv, ld;
    logic             issue_acc, nxt_free, cnt_zero, iter_start_q;
    int unsigned      iter_sel;
    logic [CNT_W-1:0] iter_ld_val;
    ct_vfdsu_tag_t    issue_tag;
    ct_vfdsu_tag_t    tag [DEPTH];
    logic             unused_wb_tag;

    always_comb begin
        issue_tag          = '0;
        issue_tag.op       = ct_vfdsu_op_e'(pif.issue_op);
        issue_tag.fmt      = ct_vfdsu_fmt_e'(pif.issue_fmt);
        issue_tag.rm       = pif.issue_rm;
        issue_tag.iid      = TAG_IID_W'(pif.issue_iid);
        issue_tag.dst_ereg = TAG_EREG_W'(pif.issue_dst_ereg);
        issue_tag.dst_vreg = TAG_VREG_W'(pif.issue_dst_vreg);
    end

    // Walk from writeback back to S1 so a drain and an upstream move share one edge.
    always_comb begin
        adv      = '0;
        nxt_free = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (k == DEPTH - 1) begin
                adv[k] = vld_q[k] & pif.wb_ack;
            end else if (k == 1) begin
                adv[k] = vld_q[k] & nxt_free & cnt_zero;
            end else begin
                adv[k] = vld_q[k] & nxt_free;
            end
            nxt_free = ~vld_q[k] | adv[k];
        end
    end

    assign pif.issue_rdy = ~pif.flush & (~vld_q[0] | adv[0]);
    assign issue_acc     = pif.issue_vld & pif.issue_rdy;
    assign ld            = {adv[DEPTH-2:0], issue_acc};
    assign vld_d         = pif.flush ? '0 : (ld | (vld_q & ~adv));

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            vld_q        <= '0;
            iter_start_q <= 1'b0;
        end else begin
            vld_q        <= vld_d;
            iter_start_q <= ld[1] & ~pif.flush;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        ct_vfdsu_tag_t tag_q;
        ct_vfdsu_tag_t tag_in;

        if (k == 0) begin : g_head
            assign tag_in = issue_tag;
        end else begin : g_body
            assign tag_in = tag[k-1];
        end

        // Tags only move on a load; an emptied or flushed stage keeps its last tag.
        always_ff @(posedge forever_cpuclk) begin
            if (cpurst) begin
                tag_q <= '0;
            end else if (ld[k] && !pif.flush) begin
                tag_q <= tag_in;
            end
        end

        assign tag[k] = tag_q;
    end

    always_comb begin
        iter_sel = ITER_D;
        case (tag[0].fmt)
            FmtSingle: iter_sel = ITER_S;
`ifdef CT_VFDSU_HALF_EN
            FmtHalf:   iter_sel = ITER_H;
`endif
            default:   iter_sel = ITER_D;
        endcase
        iter_ld_val = CNT_W'(iter_sel - 1);
    end

    ct_vfdsu_iter_cnt #(
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk      (forever_cpuclk),
        .rst      (cpurst),
        .flush    (pif.flush),
        .load     (ld[1]),
        .load_val (iter_ld_val),
        .run      (vld_q[1]),
        .zero     (cnt_zero)
    );

    assign pif.s1_vld      = vld_q[0];
    assign pif.s2_vld      = vld_q[1];
    assign pif.s1_op       = tag[0].op;
    assign pif.s1_fmt      = tag[0].fmt;
    assign pif.s1_rm       = tag[0].rm;
    assign pif.iter_start  = iter_start_q;
    assign pif.iter_last   = vld_q[1] & cnt_zero;
    assign pif.wb_vld      = vld_q[DEPTH-1];
    assign pif.wb_iid      = tag[DEPTH-1].iid[IID_W-1:0];
    assign pif.wb_dst_ereg = tag[DEPTH-1].dst_ereg[EREG_W-1:0];
    assign pif.wb_dst_vreg = tag[DEPTH-1].dst_vreg[VREG_W-1:0];
    assign pif.wb_op       = tag[DEPTH-1].op;
    assign pif.wb_fmt      = tag[DEPTH-1].fmt;
    assign pif.busy        = |vld_q;

    assign unused_wb_tag = ^tag[DEPTH-1];
endmodule

// File: tb/tb_ct_vfdsu_tag_pipe.sv
// Directed self-checking bench for ct_vfdsu_tag_pipe (DEPTH = 4, default iteration counts).
module tb_ct_vfdsu_tag_pipe;
    localparam int ITER_D = 15;
    localparam int ITER_S = 8;
    localparam int ITER_H = 4;
`ifdef CT_VFDSU_HALF_EN
    localparam int ITER_HALF = ITER_H;
`else
    localparam int ITER_HALF = ITER_D;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ct_vfdsu_tag_pipe_if #(.IID_W(7), .EREG_W(5), .VREG_W(7)) pif ();

    ct_vfdsu_tag_pipe #(
        .DEPTH  (4),
        .IID_W  (7),
        .VREG_W (7),
        .EREG_W (5),
        .ITER_D (ITER_D),
        .ITER_S (ITER_S),
        .ITER_H (ITER_H)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .pif            (pif)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        pif.issue_vld      = 1'b0;
        pif.issue_op       = 2'b00;
        pif.issue_fmt      = 2'b00;
        pif.issue_iid      = '0;
        pif.issue_dst_ereg = '0;
        pif.issue_dst_vreg = '0;
        pif.issue_rm       = 3'd0;
        pif.flush          = 1'b0;
    endtask

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic test_reset();
        idle_inputs();
        pif.wb_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (pif.issue_rdy !== 1'b1) begin bad++; $display("FAIL reset issue_rdy got %b want 1", pif.issue_rdy); end
        total++; if (pif.busy !== 1'b0) begin bad++; $display("FAIL reset busy got %b want 0", pif.busy); end
        total++; if (pif.wb_vld !== 1'b0) begin bad++; $display("FAIL reset wb_vld got %b want 0", pif.wb_vld); end
        total++; if (pif.s1_vld !== 1'b0 || pif.s2_vld !== 1'b0) begin bad++; $display("FAIL reset stage_vld got %b%b want 00", pif.s1_vld, pif.s2_vld); end
        total++; if (pif.iter_start !== 1'b0 || pif.iter_last !== 1'b0) begin bad++; $display("FAIL reset iter got %b%b want 00", pif.iter_start, pif.iter_last); end
        total++; if (pif.wb_iid !== 7'h00) begin bad++; $display("FAIL reset wb_iid got %h want 00", pif.wb_iid); end
        @(posedge clk); #1;
    endtask

    task automatic run_one(input logic [1:0] op, input logic [1:0] fmt, input logic [6:0] iid,
                           input int exp_iter, input string nm);
        int first_start, n_start, n_s2, first_wb, n_wb, busy_after, exp_wb;
        logic [6:0] got_iid, got_vreg;
        logic [4:0] got_ereg;
        logic [1:0] got_fmt, got_op;
        logic       s1_ok;
        first_start = -1; n_start = 0; n_s2 = 0; first_wb = -1; n_wb = 0; busy_after = -1;
        got_iid = '0; got_vreg = '0; got_ereg = '0; got_fmt = '0; got_op = '0; s1_ok = 1'b0;
        exp_wb = 3 + exp_iter;
        pif.wb_ack         = 1'b1;
        pif.issue_vld      = 1'b1;
        pif.issue_op       = op;
        pif.issue_fmt      = fmt;
        pif.issue_iid      = iid;
        pif.issue_dst_ereg = iid[4:0];
        pif.issue_dst_vreg = ~iid;
        pif.issue_rm       = 3'd5;
        @(negedge clk);
        total++; if (pif.issue_rdy !== 1'b1) begin bad++; $display("FAIL %s issue_rdy got %b want 1", nm, pif.issue_rdy); end
        @(posedge clk); #1;
        idle_inputs();
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) s1_ok = pif.s1_vld && pif.s1_rm == 3'd5 && pif.s1_fmt == fmt && pif.s1_op == op;
            if (pif.iter_start === 1'b1) begin if (first_start < 0) first_start = n; n_start++; end
            if (pif.s2_vld === 1'b1) n_s2++;
            if (pif.wb_vld === 1'b1) begin
                if (first_wb < 0) begin
                    first_wb = n; got_iid = pif.wb_iid; got_fmt = pif.wb_fmt; got_op = pif.wb_op;
                    got_ereg = pif.wb_dst_ereg; got_vreg = pif.wb_dst_vreg;
                end
                n_wb++;
            end
            if (n == exp_wb + 1) busy_after = int'(pif.busy);
            @(posedge clk); #1;
        end
        total++; if (!s1_ok) begin bad++; $display("FAIL %s s1_tag got op=%b fmt=%b want op=%b fmt=%b rm=5", nm, pif.s1_op, pif.s1_fmt, op, fmt); end
        total++; if (first_start != 2 || n_start != 1) begin bad++; $display("FAIL %s iter_start got at=%0d n=%0d want at=2 n=1", nm, first_start, n_start); end
        total++; if (n_s2 != exp_iter) begin bad++; $display("FAIL %s s2_cycles got %0d want %0d", nm, n_s2, exp_iter); end
        total++; if (first_wb != exp_wb || n_wb != 1) begin bad++; $display("FAIL %s wb_vld got at=%0d n=%0d want at=%0d n=1", nm, first_wb, n_wb, exp_wb); end
        total++; if (got_iid !== iid) begin bad++; $display("FAIL %s wb_iid got %h want %h", nm, got_iid, iid); end
        total++; if (got_fmt !== fmt || got_op !== op) begin bad++; $display("FAIL %s wb_fmt_op got %b/%b want %b/%b", nm, got_fmt, got_op, fmt, op); end
        total++; if (got_ereg !== iid[4:0] || got_vreg !== ~iid) begin bad++; $display("FAIL %s wb_dst got %h/%h want %h/%h", nm, got_ereg, got_vreg, iid[4:0], ~iid); end
        total++; if (busy_after != 0) begin bad++; $display("FAIL %s busy_after_wb got %0d want 0", nm, busy_after); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] iids [4];
        logic [1:0] fmts [4];
        int         starts [4];
        logic [6:0] wb_iids [4];
        logic [1:0] wb_fmts [4];
        int idx, ns, nwb;
        logic acc;
        iids = '{7'h11, 7'h12, 7'h13, 7'h00};
        fmts = '{2'b10, 2'b01, 2'b00, 2'b00};
        starts = '{0, 0, 0, 0};
        wb_iids = '{default: '0};
        wb_fmts = '{default: '0};
        idx = 0; ns = 0; nwb = 0;
        pif.wb_ack = 1'b1;
        for (int c = 0; c < 200 && nwb < 3; c++) begin
            pif.issue_vld = (idx < 3);
            pif.issue_op  = 2'b01;
            pif.issue_fmt = fmts[idx];
            pif.issue_iid = iids[idx];
            @(negedge clk);
            if (pif.iter_start === 1'b1 && ns < 4) begin starts[ns] = c; ns++; end
            if (pif.wb_vld === 1'b1 && nwb < 4) begin wb_iids[nwb] = pif.wb_iid; wb_fmts[nwb] = pif.wb_fmt; nwb++; end
            acc = pif.issue_vld && pif.issue_rdy;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        idle_inputs();
        total++; if (ns != 3 || nwb != 3) begin bad++; $display("FAIL b2b counts got starts=%0d wbs=%0d want 3/3", ns, nwb); end
        total++; if (starts[1] - starts[0] != ITER_D) begin bad++; $display("FAIL b2b spacing1 got %0d want %0d", starts[1] - starts[0], ITER_D); end
        total++; if (starts[2] - starts[1] != ITER_S) begin bad++; $display("FAIL b2b spacing2 got %0d want %0d", starts[2] - starts[1], ITER_S); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wb_iids[i] !== iids[i] || wb_fmts[i] !== fmts[i]) begin
                bad++; $display("FAIL b2b wb_order[%0d] got %h/%b want %h/%b", i, wb_iids[i], wb_fmts[i], iids[i], fmts[i]);
            end
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_backpressure();
        int idx, nwb, tag_err;
        logic acc, last_rdy, last_wb;
        logic [6:0] last_iid;
        logic [6:0] wb_iids [4];
        idx = 0; nwb = 0; tag_err = 0; last_rdy = 1'b1; last_wb = 1'b0; last_iid = '0;
        wb_iids = '{default: '0};
        pif.wb_ack = 1'b0;
        for (int c = 0; c < 40; c++) begin
            pif.issue_vld = 1'b1;
            pif.issue_op  = 2'b01;
            pif.issue_fmt = 2'b10;
            pif.issue_iid = 7'(7'h20 + idx);
            @(negedge clk);
            if (pif.wb_vld === 1'b1 && pif.wb_iid !== 7'h20) tag_err++;
            acc = pif.issue_vld && pif.issue_rdy;
            last_rdy = pif.issue_rdy; last_wb = pif.wb_vld; last_iid = pif.wb_iid;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        idle_inputs();
        total++; if (idx != 4) begin bad++; $display("FAIL bp accepted got %0d want 4", idx); end
        total++; if (last_rdy !== 1'b0) begin bad++; $display("FAIL bp issue_rdy_full got %b want 0", last_rdy); end
        total++; if (last_wb !== 1'b1 || last_iid !== 7'h20) begin bad++; $display("FAIL bp wb_hold got %b/%h want 1/20", last_wb, last_iid); end
        total++; if (tag_err != 0) begin bad++; $display("FAIL bp wb_tag_stable got %0d bad cycles want 0", tag_err); end
        pif.wb_ack = 1'b1;
        for (int c = 0; c < 200 && nwb < 4; c++) begin
            @(negedge clk);
            if (pif.wb_vld === 1'b1) begin wb_iids[nwb] = pif.wb_iid; nwb++; end
            @(posedge clk); #1;
        end
        total++; if (nwb != 4) begin bad++; $display("FAIL bp drain_count got %0d want 4", nwb); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wb_iids[i] !== 7'(7'h20 + i)) begin bad++; $display("FAIL bp drain_order[%0d] got %h want %h", i, wb_iids[i], 7'(7'h20 + i)); end
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_flush();
        int n_wb, n_busy;
        n_wb = 0; n_busy = 0;
        pif.wb_ack    = 1'b1;
        pif.issue_vld = 1'b1;
        pif.issue_fmt = 2'b10;
        pif.issue_op  = 2'b10;
        pif.issue_iid = 7'h55;
        @(posedge clk); #1;
        idle_inputs();
        repeat (6) begin @(posedge clk); #1; end
        pif.flush     = 1'b1;
        pif.issue_vld = 1'b1;
        pif.issue_iid = 7'h66;
        @(negedge clk);
        total++; if (pif.issue_rdy !== 1'b0) begin bad++; $display("FAIL flush issue_rdy got %b want 0", pif.issue_rdy); end
        total++; if (pif.s2_vld !== 1'b1 || pif.iter_last !== 1'b0) begin bad++; $display("FAIL flush mid_iter got s2=%b last=%b want 1/0", pif.s2_vld, pif.iter_last); end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        total++; if (pif.busy !== 1'b0 || pif.s1_vld !== 1'b0) begin bad++; $display("FAIL flush cleared got busy=%b s1=%b want 0/0", pif.busy, pif.s1_vld); end
        total++; if (pif.wb_vld !== 1'b0) begin bad++; $display("FAIL flush wb_vld got %b want 0", pif.wb_vld); end
        @(posedge clk); #1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (pif.wb_vld === 1'b1) n_wb++;
            if (pif.busy === 1'b1) n_busy++;
            @(posedge clk); #1;
        end
        total++; if (n_wb != 0 || n_busy != 0) begin bad++; $display("FAIL flush after got wb=%0d busy=%0d want 0/0", n_wb, n_busy); end
    endtask

    task automatic test_reset_full();
        pif.wb_ack = 1'b0;
        for (int c = 0; c < 40; c++) begin
            pif.issue_vld = 1'b1;
            pif.issue_op  = 2'b01;
            pif.issue_fmt = 2'b01;
            pif.issue_iid = 7'(7'h40 + c);
            pif.issue_rm  = 3'd3;
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        total++; if (pif.wb_vld !== 1'b1 || pif.s1_vld !== 1'b1) begin bad++; $display("FAIL rstfull pre got wb=%b s1=%b want 1/1", pif.wb_vld, pif.s1_vld); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (pif.issue_rdy !== 1'b1) begin bad++; $display("FAIL rstfull issue_rdy got %b want 1", pif.issue_rdy); end
        total++; if (pif.busy !== 1'b0 || pif.wb_vld !== 1'b0 || pif.s1_vld !== 1'b0) begin bad++; $display("FAIL rstfull vld got busy=%b wb=%b s1=%b want 000", pif.busy, pif.wb_vld, pif.s1_vld); end
        total++; if (pif.wb_iid !== 7'h00 || pif.s1_op !== 2'b00 || pif.s1_rm !== 3'd0) begin bad++; $display("FAIL rstfull tags got iid=%h op=%b rm=%0d want 0", pif.wb_iid, pif.s1_op, pif.s1_rm); end
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        pif.wb_ack = 1'b0;
        test_reset();
        run_one(2'b01, 2'b10, 7'h2A, ITER_D, "double");
        run_one(2'b10, 2'b01, 7'h15, ITER_S, "single");
        run_one(2'b10, 2'b00, 7'h33, ITER_HALF, "half");
        run_one(2'b01, 2'b11, 7'h44, ITER_D, "rsvd");
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
